// File: rtl/nios2_mul_seq.sv
// Sequential 32x32 multiplier built from four 16x16 partial products issued to an
// external pipelined multiply cell; supports MUL, MULXSS, MULXSU and MULXUU.
module nios2_mul_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_cell_result
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] FIX   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [2:0] DRAIN_LAST = 3'(CELL_LATENCY - 1);

    logic [2:0]  state;
    logic [1:0]  k;
    logic [2:0]  drain_cnt;
    logic [1:0]  op_q;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        neg_q;
    logic [63:0] acc;

    // Tag pipeline: tracks which partial product the cell is returning and its weight.
    logic [CELL_LATENCY-1:0]       vld_p;
    logic [CELL_LATENCY-1:0][1:0]  sh_p;

    logic [1:0]  issue_sh;
    logic [15:0] a_half;
    logic [15:0] b_half;
    logic [63:0] acc_fixed;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] apply_sign(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    // Weight code 0/1/2 selects a shift of 0/16/32 bits.
    function automatic logic [63:0] cell_term(input logic [31:0] p, input logic [1:0] sh);
        case (sh)
            2'd0:    return {32'h0, p};
            2'd1:    return {16'h0, p, 16'h0};
            default: return {p, 32'h0};
        endcase
    endfunction

    always_comb begin
        issue_sh  = (k == 2'd0) ? 2'd0 : ((k == 2'd3) ? 2'd2 : 2'd1);
        a_half    = k[0] ? mag1[31:16] : mag1[15:0];
        b_half    = k[1] ? mag2[31:16] : mag2[15:0];
        acc_fixed = apply_sign(acc, neg_q);
        busy      = (state != IDLE);
        done      = (state == DONE);
        mul_src1  = (state == ISSUE) ? {16'h0, a_half} : 32'h0;
        mul_src2  = (state == ISSUE) ? {16'h0, b_half} : 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
            sh_p  <= '0;
        end else begin
            vld_p[0] <= (state == ISSUE);
            sh_p[0]  <= issue_sh;
            for (int i = 1; i < CELL_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                sh_p[i]  <= sh_p[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            k         <= 2'd0;
            drain_cnt <= 3'd0;
            op_q      <= 2'd0;
            mag1      <= 32'h0;
            mag2      <= 32'h0;
            neg_q     <= 1'b0;
            acc       <= 64'h0;
            result    <= 32'h0;
        end else begin
            if (vld_p[CELL_LATENCY-1])
                acc <= acc + cell_term(mul_cell_result, sh_p[CELL_LATENCY-1]);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        mag1  <= magnitude(src1, (op == 2'b01) || (op == 2'b10));
                        mag2  <= magnitude(src2, (op == 2'b01));
                        neg_q <= (op == 2'b01) ? (src1[31] ^ src2[31]) :
                                 (op == 2'b10) ? src1[31] : 1'b0;
                        acc   <= 64'h0;
                        k     <= 2'd0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        drain_cnt <= 3'd0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
                    if (drain_cnt == DRAIN_LAST)
                        state <= FIX;
                end
                FIX: begin
                    acc    <= acc_fixed;
                    result <= (op_q == 2'b00) ? acc_fixed[31:0] : acc_fixed[63:32];
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_mul_seq.sv
// Directed bench for nios2_mul_seq: one instance with a 1-cycle cell, one with a 3-cycle cell.
module tb_nios2_mul_seq;

    logic        clk;
    logic        reset_n;
    logic        start1, start3;
    logic [1:0]  op;
    logic [31:0] src1, src2;

    logic        busy1, done1, busy3, done3;
    logic [31:0] result1, ms1_1, ms2_1, cell1;
    logic [31:0] result3, ms1_3, ms2_3, cell3;

    logic [31:0] c1_q;
    logic [31:0] c3_q [3];

    int checks;
    int failures;

    nios2_mul_seq #(.CELL_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .op(op), .src1(src1), .src2(src2),
        .busy(busy1), .done(done1), .result(result1),
        .mul_src1(ms1_1), .mul_src2(ms2_1), .mul_cell_result(cell1)
    );

    nios2_mul_seq #(.CELL_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .op(op), .src1(src1), .src2(src2),
        .busy(busy3), .done(done3), .result(result3),
        .mul_src1(ms1_3), .mul_src2(ms2_3), .mul_cell_result(cell3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiply cell models: low 32 bits of mul_src1 x mul_src2[15:0], delayed 1 or 3 cycles.
    always @(posedge clk) begin
        c1_q    <= ms1_1 * {16'h0, ms2_1[15:0]};
        c3_q[0] <= ms1_3 * {16'h0, ms2_3[15:0]};
        c3_q[1] <= c3_q[0];
        c3_q[2] <= c3_q[1];
    end
    assign cell1 = c1_q;
    assign cell3 = c3_q[2];

    typedef struct {
        logic        sel;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic sel, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string name);
        int lat, first, n_done;
        logic busy_ok, d, bz;
        logic [31:0] r;
        lat = sel ? 8 : 6;
        first = -1;
        n_done = 0;
        busy_ok = 1'b1;
        r = 32'h0;
        @(negedge clk);
        op = o; src1 = a; src2 = b;
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
        op = ~o; src1 = ~a; src2 = b ^ 32'h5A5A5A5A;
        if (!(sel ? busy3 : busy1)) busy_ok = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            d  = sel ? done3 : done1;
            bz = sel ? busy3 : busy1;
            if (d) begin
                n_done++;
                if (first < 0) first = n;
                r = sel ? result3 : result1;
            end
            if (n <= lat && !bz) busy_ok = 1'b0;
            if (n == lat + 1 && bz) busy_ok = 1'b0;
        end
        check({name, "_done_edge"}, 64'(first), 64'(lat));
        check({name, "_done_count"}, 64'(n_done), 64'd1);
        check({name, "_result"}, {32'h0, r}, {32'h0, exp});
        check({name, "_busy"}, {63'h0, busy_ok}, 64'd1);
        check({name, "_hold"}, {32'h0, sel ? result3 : result1}, {32'h0, exp});
    endtask

    initial begin
        logic [31:0] expect_mix;
        int n_done;
        logic [63:0] full;

        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        start1 = 1'b0; start3 = 1'b0;
        op = 2'b11; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF;

        vecs[0]  = '{1'b0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{1'b0, 2'b00, 32'h00010001, 32'h00010001, 32'h00020001};
        vecs[2]  = '{1'b0, 2'b11, 32'h00010001, 32'h00010001, 32'h00000001};
        vecs[3]  = '{1'b0, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[4]  = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        vecs[5]  = '{1'b0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[6]  = '{1'b0, 2'b11, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[7]  = '{1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[8]  = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{1'b0, 2'b00, 32'h00000007, 32'h00000009, 32'h0000003F};
        vecs[10] = '{1'b0, 2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
        vecs[11] = '{1'b0, 2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA};
        vecs[12] = '{1'b0, 2'b01, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF};
        vecs[13] = '{1'b0, 2'b11, 32'h00010000, 32'h00010000, 32'h00000001};
        vecs[14] = '{1'b0, 2'b11, 32'hFFFF0000, 32'h0000FFFF, 32'h0000FFFE};
        vecs[15] = '{1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[16] = '{1'b1, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[17] = '{1'b1, 2'b00, 32'h00010001, 32'h00010001, 32'h00020001};

        #23;
        check("rst_busy", {63'h0, busy1}, 64'd0);
        check("rst_done", {63'h0, done1}, 64'd0);
        check("rst_result", {32'h0, result1}, 64'd0);
        check("rst_mul_src1", {32'h0, ms1_1}, 64'd0);
        check("rst_mul_src2", {32'h0, ms2_1}, 64'd0);
        check("rst_busy3", {63'h0, busy3}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++)
            run_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Operand issue order and zero outside ISSUE.
        full = 64'h12345678 * 64'h9ABCDEF0;
        expect_mix = full[63:32];
        @(negedge clk);
        op = 2'b11; src1 = 32'h12345678; src2 = 32'h9ABCDEF0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("issue_k0", {ms1_1, ms2_1}, {32'h00005678, 32'h0000DEF0});
        @(posedge clk); #1;
        check("issue_k1", {ms1_1, ms2_1}, {32'h00001234, 32'h0000DEF0});
        @(posedge clk); #1;
        check("issue_k2", {ms1_1, ms2_1}, {32'h00005678, 32'h00009ABC});
        @(posedge clk); #1;
        check("issue_k3", {ms1_1, ms2_1}, {32'h00001234, 32'h00009ABC});
        @(posedge clk); #1;
        check("drain_zero", {ms1_1, ms2_1}, 64'h0);
        for (int n = 0; n < 12; n++) @(posedge clk);
        #1;
        check("mix_result", {32'h0, result1}, {32'h0, expect_mix});

        // Second start during busy is ignored.
        n_done = 0;
        @(negedge clk);
        op = 2'b11; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done1) n_done++;
        end
        check("busy_start_dones", 64'(n_done), 64'd1);
        check("busy_start_result", {32'h0, result1}, 64'hFFFFFFFE);

        // Reset during ISSUE k=2 aborts the operation.
        @(negedge clk);
        op = 2'b00; src1 = 32'h00010001; src2 = 32'h00010001; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_abort_busy", {63'h0, busy1}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {63'h0, busy1}, 64'd0);
        check("abort_done", {63'h0, done1}, 64'd0);
        check("abort_result", {32'h0, result1}, 64'd0);
        check("abort_mul_src", {ms1_1, ms2_1}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_done = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done1) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_result_after", {32'h0, result1}, 64'd0);
        run_op(1'b0, 2'b11, 32'd7, 32'd9, 32'h00000000, "post_reset");
        run_op(1'b0, 2'b00, 32'd7, 32'd9, 32'h0000003F, "post_reset_lo");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios2_mul_seq.md
NIOS2_MUL_SEQ -- requirements
Module: nios2_mul_seq

Interface
REQ-001 The block SHALL have one parameter: CELL_LATENCY, default 1, meaning the number of clock cycles from driving mul_src1/mul_src2 until the matching mul_cell_result is valid (legal range 1-4).
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low 32 bits), 01 MULXSS, 10 MULXSU, 11 MULXUU (high 32 bits).
- src1  input  32  multiplicand; signed for op 01/10.
- src2  input  32  multiplier; signed for op 01 only.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  product word.
- mul_src1  output  32  operand A to the downstream 32x16 multiply cell.
- mul_src2  output  32  operand B to the downstream 32x16 multiply cell.
- mul_cell_result  input  32  cell product, valid CELL_LATENCY cycles after issue.

Function
REQ-003 The block SHALL be an FSM with states IDLE, ISSUE, DRAIN, FIX and DONE.
REQ-004 In IDLE, when start=1 at edge E0, the block SHALL capture op, |src1| and |src2| as 32-bit magnitudes, capture the product sign, clear the 64-bit accumulator, set k=0 and enter ISSUE.
REQ-005 Magnitude rule: an operand SHALL be treated as signed only where op marks it signed; 0x80000000 SHALL map to magnitude 0x80000000.
REQ-006 Product sign SHALL be src1[31]^src2[31] for op 01, src1[31] for op 10, and 0 for op 00/11.
REQ-007 ISSUE SHALL last exactly 4 cycles (k=0..3), driving mul_src1={16'h0, a_i} and mul_src2={16'h0, b_j}, with (i,j)=(0,0),(1,0),(0,1),(1,1) for k=0..3, where a1/a0 and b1/b0 are the high/low halfwords of the magnitudes.
REQ-008 The block SHALL add each cell result, zero-extended and shifted left by 16*(i+j), into the 64-bit accumulator at the edge CELL_LATENCY+1 edges after the edge that began its issue cycle; carries SHALL propagate through all 64 bits.
REQ-009 After ISSUE the block SHALL stay in DRAIN for CELL_LATENCY cycles, then spend 1 cycle in FIX, then enter DONE.
REQ-010 FIX SHALL two's-complement negate the 64-bit accumulator when the product sign is 1, and leave it unchanged otherwise.
REQ-011 On entry to DONE, result SHALL load accumulator[31:0] for op 00 and accumulator[63:32] otherwise; done SHALL be 1 for that single cycle, then the FSM SHALL return to IDLE.
REQ-012 Latency: with start sampled at E0, done SHALL be high in the cycle following edge E(5+CELL_LATENCY); with the default this is E6. Throughput SHALL be one operation per 7+CELL_LATENCY cycles.
REQ-013 result SHALL hold its value between DONE states.
REQ-014 mul_src1 and mul_src2 SHALL be 0 outside ISSUE.
REQ-015 start while busy=1 SHALL be ignored, with no queuing.
REQ-016 start in the DONE cycle SHALL be ignored; start is accepted on the next IDLE cycle.
REQ-017 op and src1/src2 changes after E0 SHALL NOT affect the operation in progress.

Reset
REQ-018 While reset_n=0 the block SHALL force state=IDLE, busy=0, done=0, result=0, mul_src1=0, mul_src2=0, accumulator=0 and k=0, asynchronously.
REQ-019 Reset asserted mid-operation SHALL abort it: no done pulse, and in-flight cell results SHALL be discarded.
REQ-020 After reset_n rises, the first start sampled in IDLE SHALL execute normally.

Verification
REQ-021 op=11, src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result=0xFFFFFFFE, done high exactly in the cycle after E6, busy high from E0 to E6.
REQ-022 op=00, src1=0x00010001, src2=0x00010001 -> result=0x00020001; repeating with op=11 -> 0x00000001.
REQ-023 op=01 with 0x80000000 x 0x80000000 -> 0x40000000; op=01 with 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-024 op=10, src1=0xFFFFFFFF, src2=0xFFFFFFFF -> 0xFFFFFFFF; op=11 with 0x00000000 x 0xFFFFFFFF -> 0x00000000.
REQ-025 A second start pulsed at E2 is ignored, so exactly one done occurs; reset_n pulsed low during ISSUE k=2 -> all outputs 0 immediately, no done, and a following op=11 7x9 operation yields 0x00000000 with correct timing.
REQ-026 Rerun REQ-021 with CELL_LATENCY=3 and a 3-cycle cell model -> same result, done in the cycle after E8.
